// File: rtl/remote_comm_pkg.sv
// Shared types and constants for the remote_comm serial command link.
// The receive path is built only when REMOTE_COMM_RX_EN is defined.
package remote_comm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } tx_state_t;

  localparam int BAUD_DIV_DEFAULT = 2604;
  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam int FRAME_BITS = 10;

  // 8N1 frame, bit 0 goes on the wire first
  function automatic logic [9:0] frame8n1(
    input logic [7:0] d
  );
    return {1'b1, d, 1'b0};
  endfunction

endpackage

// File: rtl/uart_xcvr.sv
// 8N1 UART transmitter and, with REMOTE_COMM_RX_EN, receiver.
// tx_done is combinational so a new frame can start with no idle gap.
module uart_xcvr
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done
`ifdef REMOTE_COMM_RX_EN
  ,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid
`endif
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  logic [9:0]    tx_sh;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic          tx_busy;
  logic          tx_tick;

  assign tx_tick = tx_busy && (tx_cnt == BIT_END);
  assign tx_done = tx_tick && (tx_bit == LAST_BIT);
  assign tx      = tx_sh[0];

  // Idle shifter is all ones, so TX is a flop that resets high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh   <= '1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_busy <= 1'b0;
    end else if (tx_start) begin
      tx_sh   <= frame8n1(tx_data);
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_busy <= 1'b1;
    end else if (tx_busy) begin
      if (tx_tick) begin
        tx_cnt <= '0;
        tx_sh  <= {1'b1, tx_sh[9:1]};
        if (tx_done) begin
          tx_busy <= 1'b0;
        end else begin
          tx_bit <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

`ifdef REMOTE_COMM_RX_EN
  logic [1:0]    rx_sync;
  logic          rx_s;
  logic          rx_prev;
  logic          rx_busy;
  logic [CW-1:0] rx_cnt;
  logic [CW-1:0] rx_thr;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;

  assign rx_s = rx_sync[1];
  // First wait is half a bit to land mid start bit
  assign rx_thr = (rx_bit == 4'd0) ? HALF_END : BIT_END;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], rx};
      rx_prev  <= rx_s;
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_s) begin
          rx_busy <= 1'b1;
          rx_cnt  <= '0;
          rx_bit  <= '0;
        end
      end else if (rx_cnt == rx_thr) begin
        rx_cnt <= '0;
        rx_bit <= rx_bit + 4'd1;
        unique case (1'b1)
          (rx_bit == 4'd0): begin
            if (rx_s) rx_busy <= 1'b0;
          end
          (rx_bit == LAST_BIT): begin
            rx_busy <= 1'b0;
            if (rx_s) begin
              rx_data  <= rx_sh;
              rx_valid <= 1'b1;
            end
          end
          default: begin
            rx_sh <= {rx_s, rx_sh[7:1]};
          end
        endcase
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/remote_comm.sv
// Host-side command transmitter / response receiver for the robot link.
// Define REMOTE_COMM_RX_EN to build the response receiver.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  tx_state_t   state;
  tx_state_t   state_nxt;
  logic [15:0] cmd_q;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        accept;
  logic        set_sent;

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    tx_data   = cmd_q[15:8];
    accept    = 1'b0;
    set_sent  = 1'b0;
    unique case (state)
      IDLE: begin
        if (send_cmd) begin
          accept    = 1'b1;
          tx_start  = 1'b1;
          tx_data   = cmd[15:8];
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (tx_done) begin
          tx_start  = 1'b1;
          tx_data   = cmd_q[7:0];
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (tx_done) begin
          set_sent  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cmd_q    <= '0;
      cmd_sent <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd_q    <= cmd;
        cmd_sent <= 1'b0;
      end else if (set_sent) begin
        cmd_sent <= 1'b1;
      end
    end
  end

`ifdef REMOTE_COMM_RX_EN
  uart_xcvr #(
    .BAUD_DIV(BAUD_DIV)
  ) u_xcvr (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (TX),
    .tx_done  (tx_done),
    .rx       (RX),
    .rx_data  (resp),
    .rx_valid (resp_rdy)
  );
`else
  logic rx_unused;
  assign rx_unused = RX;
  assign resp_rdy  = 1'b0;
  assign resp      = 8'h00;

  uart_xcvr #(
    .BAUD_DIV(BAUD_DIV)
  ) u_xcvr (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (TX),
    .tx_done  (tx_done)
  );
`endif

endmodule

// File: tb/tb_remote_comm.sv
// Self-checking bench for remote_comm: TX vector table, random commands,
// RX frames checked against a simple response model.
module tb_remote_comm;
  import remote_comm_pkg::*;

  localparam int BD = 16;

`ifdef REMOTE_COMM_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd = '0;
  logic        send_cmd = 1'b0;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] model_resp = 8'h00;

  always #5 clk = ~clk;

  remote_comm #(
    .BAUD_DIV(BD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .TX       (TX),
    .cmd      (cmd),
    .send_cmd (send_cmd),
    .cmd_sent (cmd_sent),
    .resp_rdy (resp_rdy),
    .resp     (resp)
  );

  typedef struct {
    logic [15:0] cmd;
    int          glitch;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } tx_vec_t;

  typedef struct {
    logic [7:0] b;
    logic       stop;
  } rx_vec_t;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line model: 20 bits, high byte frame then low byte frame
  task automatic send_check(input logic [15:0] c,
                            input int glitch,
                            input logic [7:0] hi,
                            input logic [7:0] lo);
    logic [19:0] got;
    int t_sent;
    int rises;
    logic prev_sent;
    logic idle_ok;
    got = '0;
    t_sent = -1;
    rises = 0;
    idle_ok = 1'b1;
    step();
    cmd = c;
    send_cmd = 1'b1;
    step();
    send_cmd = 1'b0;
    cmd = ~c;
    check("cmd_sent_clear", cmd_sent, 0);
    prev_sent = 1'b0;
    for (int k = 0; k < 23 * BD; k++) begin
      if (k == glitch) begin
        send_cmd = 1'b1;
        cmd = 16'hFFFF;
      end else begin
        send_cmd = 1'b0;
      end
      if ((k % BD) == BD / 2 && (k / BD) < 20) got[k / BD] = TX;
      if (cmd_sent && !prev_sent) begin
        rises++;
        if (t_sent < 0) t_sent = k;
      end
      prev_sent = cmd_sent;
      if (t_sent >= 0 && TX !== 1'b1) idle_ok = 1'b0;
      step();
    end
    send_cmd = 1'b0;
    check("hi_byte", got[8:1], hi);
    check("hi_start_stop", {got[9], got[0]}, 2'b10);
    check("lo_byte", got[18:11], lo);
    check("lo_start_stop", {got[19], got[10]}, 2'b10);
    check("cmd_sent_rises", rises, 1);
    check("tx_idle_after", idle_ok, 1);
    n_cmp++;
    if (t_sent < 20 * BD - 1 || t_sent > 20 * BD + 3) begin
      n_bad++;
      $display("FAIL cmd_sent_latency: got %0d expected %0d+-2",
               t_sent, 20 * BD + 1);
    end
  endtask

  task automatic rx_check(input logic [7:0] b, input logic stop);
    int pulses;
    int lat;
    logic [7:0] at_pulse;
    int exp_pulses;
    pulses = 0;
    lat = -1;
    at_pulse = '0;
    if (RX_EN && stop) begin
      model_resp = b;
      exp_pulses = 1;
    end else begin
      exp_pulses = 0;
    end
    fork
      begin
        RX = 1'b0;
        repeat (BD) step();
        for (int i = 0; i < 8; i++) begin
          RX = b[i];
          repeat (BD) step();
        end
        RX = stop;
        repeat (BD) step();
        RX = 1'b1;
        repeat (2 * BD) step();
      end
      begin
        for (int k = 0; k < 13 * BD; k++) begin
          step();
          if (resp_rdy === 1'b1) begin
            pulses++;
            at_pulse = resp;
            lat = k;
          end
        end
      end
    join
    check("resp_rdy_pulses", pulses, exp_pulses);
    check("resp_held", resp, model_resp);
    if (pulses == 1) begin
      check("resp_at_pulse", at_pulse, model_resp);
      n_cmp++;
      if (lat < (19 * BD) / 2 || lat > (19 * BD) / 2 + 6) begin
        n_bad++;
        $display("FAIL resp_rdy_latency: got %0d expected ~%0d",
                 lat, (19 * BD) / 2 + 3);
      end
    end
  endtask

  tx_vec_t tv[4];
  rx_vec_t rv[3];

  initial begin
    logic [15:0] rc;
    logic [7:0]  rb;

    tv[0] = '{16'h2000, -1, 8'h20, 8'h00};
    tv[1] = '{16'h4BF1, 5, 8'h4B, 8'hF1};
    tv[2] = '{16'h0001, 200, 8'h00, 8'h01};
    tv[3] = '{16'hFFFF, 100, 8'hFF, 8'hFF};
    rv[0] = '{POS_ACK, 1'b1};
    rv[1] = '{8'h5A, 1'b0};
    rv[2] = '{8'h33, 1'b1};

    repeat (3) step();
    check("rst_tx", TX, 1);
    check("rst_cmd_sent", cmd_sent, 0);
    check("rst_resp_rdy", resp_rdy, 0);
    check("rst_resp", resp, 8'h00);
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_tx", TX, 1);
    check("post_rst_cmd_sent", cmd_sent, 0);

    for (int i = 0; i < 4; i++) begin
      send_check(tv[i].cmd, tv[i].glitch, tv[i].hi, tv[i].lo);
    end
    check("cmd_sent_level", cmd_sent, 1);

    for (int i = 0; i < 4; i++) begin
      rc = 16'($urandom);
      send_check(rc, $urandom_range(0, 20 * BD - 2), rc[15:8], rc[7:0]);
    end

    for (int i = 0; i < 3; i++) begin
      rx_check(rv[i].b, rv[i].stop);
    end
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      rx_check(rb, $urandom_range(0, 3) != 0);
    end

    // Reset inside the low-byte start bit
    step();
    cmd = 16'h1234;
    send_cmd = 1'b1;
    step();
    send_cmd = 1'b0;
    repeat (10 * BD + 3) step();
    check("low_start_bit", TX, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", TX, 1);
    check("rst_mid_cmd_sent", cmd_sent, 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    send_check(16'hC35A, -1, 8'hC3, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
